// File: rtl/alu_host_sequencer.sv
// Host-side sequencer for a multi-cycle arithmetic unit: accepts one request,
// streams operands to the unit, collects a two-word result and hands it back.
module alu_host_sequencer #(
  parameter int TIMEOUT = 200
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_opcode,
  input  logic [63:0] req_a,
  input  logic [63:0] req_b,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [63:0] res_hi,
  output logic [63:0] res_lo,
  output logic        res_err,
  output logic        au_bgn,
  output logic [1:0]  au_opcode,
  output logic [63:0] au_inbus,
  input  logic        au_stop,
  input  logic [63:0] au_outbus
);

  localparam int DATA_W = 64;
  localparam int CNT_W  = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_LOAD_A, S_LOAD_B, S_WAIT, S_CAP_LO, S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          op_q;
  logic [DATA_W-1:0]   a_q, b_q;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   res_hi_q, res_hi_d;
  logic [DATA_W-1:0]   res_lo_q, res_lo_d;
  logic                res_err_q, res_err_d;
  logic                div_zero;
  logic                timeout;

  assign div_zero = (req_opcode == OP_DIV) && (req_b == '0);
  assign timeout  = (cnt_q == CNT_LAST);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      res_hi_q  <= '0;
      res_lo_q  <= '0;
      res_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      res_hi_q  <= res_hi_d;
      res_lo_q  <= res_lo_d;
      res_err_q <= res_err_d;
    end
  end

  // Operand latches only matter between acceptance and CAP_LO, so no reset.
  always_ff @(posedge clk) begin
    if (state_q == S_IDLE && req_valid) begin
      op_q <= req_opcode;
      a_q  <= req_a;
      b_q  <= req_b;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (req_valid) state_d = div_zero ? S_DONE : S_START;
      S_START:  state_d = S_LOAD_A;
      S_LOAD_A: state_d = S_LOAD_B;
      S_LOAD_B: state_d = S_WAIT;
      S_WAIT: begin
        if (au_stop)      state_d = S_CAP_LO;
        else if (timeout) state_d = S_DONE;
      end
      S_CAP_LO: state_d = S_DONE;
      S_DONE:   if (res_ready) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Result capture; au_stop takes priority over a coincident timeout.
  always_comb begin
    res_hi_d  = res_hi_q;
    res_lo_d  = res_lo_q;
    res_err_d = res_err_q;
    cnt_d     = (state_q == S_WAIT) ? cnt_q + CNT_W'(1) : '0;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid && div_zero) begin
          res_hi_d  = '1;
          res_lo_d  = '1;
          res_err_d = 1'b1;
        end
      end
      S_WAIT: begin
        if (au_stop) begin
          res_hi_d = au_outbus;
        end else if (timeout) begin
          res_hi_d  = '0;
          res_lo_d  = '0;
          res_err_d = 1'b1;
        end
      end
      S_CAP_LO: begin
        res_lo_d  = au_outbus;
        res_err_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_comb begin
    req_ready = (state_q == S_IDLE) && rst_b;
    res_valid = (state_q == S_DONE);
    au_bgn    = (state_q == S_START);
    au_opcode = 2'b00;
    au_inbus  = '0;
    unique case (state_q)
      S_START, S_WAIT, S_CAP_LO: au_opcode = op_q;
      S_LOAD_A: begin
        au_opcode = op_q;
        au_inbus  = a_q;
      end
      S_LOAD_B: begin
        au_opcode = op_q;
        au_inbus  = b_q;
      end
      default: ;
    endcase
  end

  assign res_hi  = res_hi_q;
  assign res_lo  = res_lo_q;
  assign res_err = res_err_q;

endmodule
